instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Maintains the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel. Buffers in-order responses in a small FIFO and presents one instruction per cycle, with its PC, to decode over a valid/ready handshake. Supports a redirect input (branch/jump target) that flushes buffered and in-flight fetches.

## Interface
- DWIDTH, 32, instruction width in bits (matches decoder instr width)
- AWIDTH, 32, PC / memory address width in bits
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- DEPTH, 2, FIFO entries; also the maximum outstanding-plus-buffered fetches

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  AWIDTH  byte address of fetch, bits [1:0] always 0
- imem_rsp_valid  in  1  response data valid; in request order, latency >= 1 cycle, no backpressure
- imem_rsp_data  in  DWIDTH  fetched instruction word
- redirect_valid  in  1  one-cycle pulse: discard pending work, restart fetch at redirect_pc
- redirect_pc  in  AWIDTH  new fetch address; bits [1:0] ignored (forced 0)
- instr_valid  out  1  instr/instr_pc hold a valid fetched instruction
- instr_ready  in  1  decode consumes the instruction this cycle
- instr  out  DWIDTH  instruction word to decode
- instr_pc  out  AWIDTH  address of instr

## Operation
- Counters: pc (AWIDTH), outstanding (requests accepted, response not yet returned), fifo count.
- Issue rule: imem_req_valid = (state == RUN) && (outstanding + count < DEPTH) && !redirect_valid. Request handshake (valid && ready) -> pc += 4, modulo 2^AWIDTH (0xFFFF_FFFC wraps to 0), outstanding++.
- Response in RUN: push {rsp_data, pc of that request} into FIFO; outstanding--. The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
- Request PC tracking: a second small queue (or pc minus 4*(outstanding+count) arithmetic) supplies instr_pc. Either is acceptable, but instr_pc must equal the address issued for that word.
- Pop: instr_valid && instr_ready. Push and pop in the same cycle are both honoured; count is unchanged.
- FSM states:
  - RUN: normal operation.
  - FLUSH: drop every response until outstanding == 0; no requests issued.
- Redirect, in any state:
  - FIFO cleared; pc <= {redirect_pc[AWIDTH-1:2], 2'b00}.
  - If outstanding (after this cycle's response/handshake updates) == 0 -> RUN, else -> FLUSH.
- Responses in FLUSH: discarded; outstanding--. When outstanding reaches 0 -> RUN.
- Redirect arriving during FLUSH: updates pc and stays in FLUSH.
- Simultaneous redirect + response in the same cycle: the response is discarded. Simultaneous redirect + pop: the pop is ignored, because the FIFO clears.

## Timing
- Reset (rst_n low, asynchronous): pc = RESET_PC, state = RUN, outstanding = 0, count = 0.
- Output values during reset: imem_req_valid = 0 (forced while rst_n low), imem_req_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
- First request is asserted combinationally in the first cycle after rst_n deasserts.
- Outputs instr_valid, instr and instr_pc come from FIFO registers, with no combinational path from imem_rsp_*. Minimum fetch-to-decode latency: request handshake cycle N, response cycle N+1, instr_valid cycle N+2.
- imem_req_valid and imem_req_addr depend only on registered state and redirect_valid (no path from imem_req_ready).
- Once asserted, imem_req_valid and imem_req_addr stay stable until the handshake, unless a redirect occurs.
- The instr_valid/instr/instr_pc triple stays stable until popped or until a redirect occurs.
- Redirect in cycle N: instr_valid = 0 in cycle N+1. The first request to the new pc is in cycle N+1 (from RUN), or in the cycle after the last stale response (from FLUSH).
- Reset mid-operation: all in-flight responses are forgotten; memory must also be reset by the same rst_n.

## Structure
- Shared package ifetch_pkg:
  - state typedef {RUN, FLUSH}
  - INSTR_BYTES = 4
  - RESET_PC default
- Sub-module fetch_fifo:
  - parameterised width and DEPTH, synchronous clear input, full/empty/count outputs.
  - Instantiated once with width DWIDTH+AWIDTH.

## Test plan
- Reset release, imem_req_ready = 1, fixed 1-cycle response latency, instr_ready = 1 -> addresses 0x0, 0x4, 0x8... issued. instr_pc sequence 0x0, 0x4, 0x8 with matching data; after warm-up, one instruction per cycle.
- instr_ready = 0 for 10 cycles -> at most DEPTH requests issued, then imem_req_valid = 0. Release -> instructions 0x0, 0x4 delivered in order, no loss or duplicate.
- Redirect to 0x100 with 2 requests outstanding and 3-cycle response latency -> FLUSH; both stale responses dropped; next request at 0x100; the first delivered instr_pc is 0x100.
- Redirect coincident with a response and with a pop -> response discarded, FIFO empty next cycle, fetch resumes at target. Redirect_pc 0x203 -> request at 0x200.
- RESET_PC = 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- rst_n pulsed low mid-stream with a full FIFO -> instr_valid drops immediately (asynchronous). After release, fetch restarts at RESET_PC, with outstanding = 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : ifetch_pkg

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO with clear, buffering fetched words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Upstream credit accounting must make an overflowing push impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !clr_i));

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC generation, credit-limited imem requests and decode handoff.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [AWIDTH-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DWIDTH-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  state_e              state_q;
  state_e              state_d;
  logic [AWIDTH-1:0]   pc_q;
  logic [AWIDTH-1:0]   pc_d;
  logic [CW-1:0]       outst_q;
  logic [CW-1:0]       outst_d;

  logic                req_hs;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [AWIDTH-1:0]   rsp_pc;
  logic [DWIDTH+AWIDTH-1:0] fifo_dout;
  logic                unused_bits;

  assign req_hs = imem_req_valid && imem_req_ready;

  // In RUN the outstanding requests are the last outst_q addresses before pc_q,
  // so the oldest one (the one responding now) sits outst_q words back.
  assign rsp_pc = pc_q - (AWIDTH'(outst_q) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
    end
  end

  always_comb begin
    outst_d = outst_q;
    case ({req_hs, imem_rsp_valid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[AWIDTH-1:2], 2'b00};
    end else if (req_hs) begin
      pc_d = pc_q + AWIDTH'(INSTR_BYTES);
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (outst_d == '0) ? RUN : FLUSH;
    end else if ((state_q == FLUSH) && (outst_d == '0)) begin
      state_d = RUN;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    fifo_push      = 1'b0;
    if (state_q == RUN) begin
      imem_req_valid = rst_n && !redirect_valid &&
                       (({1'b0, outst_q} + {1'b0, fifo_count}) < SW'(DEPTH));
      fifo_push      = imem_rsp_valid && !redirect_valid;
    end
  end

  assign imem_req_addr = pc_q;
  assign fifo_pop      = instr_valid && instr_ready && !redirect_valid;

  fetch_fifo #(
    .WIDTH (DWIDTH + AWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_valid),
    .push_i  (fifo_push),
    .data_i  ({imem_rsp_data, rsp_pc}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid        = !fifo_empty;
  assign {instr, instr_pc}  = fifo_empty ? '0 : fifo_dout;

  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

  a_rsp_has_request : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst_q != '0));

endmodule : instr_fetch

`default_nettype wire
